// File: rtl/ber_scan_pkg.sv
// ============================================================================
// Module      : ber_scan_pkg
// Description : Shared state encoding, widths and compare helpers for the
//               BER phase scan controller.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package ber_scan_pkg;

    localparam logic [2:0] C_ST_IDLE      = 3'd0;
    localparam logic [2:0] C_ST_RESTART   = 3'd1;
    localparam logic [2:0] C_ST_GUARD     = 3'd2;
    localparam logic [2:0] C_ST_WAIT      = 3'd3;
    localparam logic [2:0] C_ST_EVAL      = 3'd4;
    localparam logic [2:0] C_ST_FINAL_RST = 3'd5;
    localparam logic [2:0] C_ST_LOCKED    = 3'd6;

    typedef enum logic [2:0] {
        ST_IDLE      = C_ST_IDLE,
        ST_RESTART   = C_ST_RESTART,
        ST_GUARD     = C_ST_GUARD,
        ST_WAIT      = C_ST_WAIT,
        ST_EVAL      = C_ST_EVAL,
        ST_FINAL_RST = C_ST_FINAL_RST,
        ST_LOCKED    = C_ST_LOCKED
    } scan_state_e;

    localparam int C_MAX_CNT_W   = 64;
    localparam int N_PHASES_DFLT = 4;
    localparam int NB_PHASES     = $clog2(N_PHASES_DFLT);

    // Phase select width, never narrower than one bit.
    function automatic int nb_phase_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // Counter-reached test where a limit the counter cannot represent is
    // clamped to the counter's maximum, so an oversized limit still ends.
    function automatic logic sat_reached(
        input logic [C_MAX_CNT_W-1:0] cnt,
        input logic [C_MAX_CNT_W-1:0] lim,
        input int                     cnt_w
    );
        logic [C_MAX_CNT_W-1:0] cap;
        cap = (cnt_w >= C_MAX_CNT_W) ? '1
            : ((C_MAX_CNT_W'(1) << cnt_w) - C_MAX_CNT_W'(1));
        return cnt >= ((lim > cap) ? cap : lim);
    endfunction

endpackage

`default_nettype wire

// File: rtl/ber_scan_timer.sv
// ============================================================================
// Module      : ber_scan_timer
// Description : Saturating watchdog counter for one measurement window.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module ber_scan_timer #(
    parameter int          NB_TIMER       = 32,
    parameter int unsigned TIMEOUT_CYCLES = 4000000
) (
    input  logic clk,
    input  logic i_rst,
    input  logic i_clear,
    input  logic i_run,
    output logic o_expire
);

    logic [NB_TIMER-1:0] r_count;

    always_ff @(posedge clk) begin
        if (i_rst || i_clear) begin
            r_count <= '0;
        end else if (i_run && (r_count != '1)) begin
            r_count <= r_count + NB_TIMER'(1);
        end
    end

    assign o_expire = (r_count == NB_TIMER'(TIMEOUT_CYCLES - 1));

endmodule

`default_nettype wire

// File: rtl/ber_phase_scan_ctrl.sv
// ============================================================================
// Module      : ber_phase_scan_ctrl
// Description : Scans every sampling phase with the BER checker, then locks
//               the phase with the fewest errors. Optional auto-rescan on
//               rising error count is compiled in with BER_SCAN_RESCAN_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module ber_phase_scan_ctrl
    import ber_scan_pkg::*;
#(
    parameter int          N_PHASES       = 4,
    parameter int          NB_BER_CNT     = 64,
    parameter int unsigned MEAS_SAMPLES   = 600000,
    parameter int          NB_TIMER       = 32,
    parameter int unsigned TIMEOUT_CYCLES = 4000000,
    localparam int         NB_PH_SEL      = nb_phase_w(N_PHASES)
) (
    input  logic                  clk,
    input  logic                  i_rst,
    input  logic                  i_start,
    input  logic [NB_BER_CNT-1:0] i_ber_samp,
    input  logic [NB_BER_CNT-1:0] i_ber_error,
`ifdef BER_SCAN_RESCAN_EN
    input  logic [NB_BER_CNT-1:0] i_rescan_thr,
`endif
    output logic                  o_ber_rst,
    output logic                  o_ber_en,
    output logic [NB_PH_SEL-1:0]  o_phase_sel,
    output logic                  o_busy,
    output logic                  o_locked,
    output logic [NB_PH_SEL-1:0]  o_best_phase,
    output logic [NB_BER_CNT-1:0] o_best_err,
    output logic                  o_timeout
);

    scan_state_e           r_state, w_state_nxt;
    logic [NB_PH_SEL-1:0]  r_ph, w_ph_nxt;
    logic [NB_PH_SEL-1:0]  r_best_ph, w_best_ph_nxt;
    logic [NB_BER_CNT-1:0] r_best_err, w_best_err_nxt;
    logic [NB_BER_CNT-1:0] r_err, w_err_nxt;
    logic                  r_timeout, w_timeout_nxt;
    logic                  r_ber_rst, w_ber_rst_nxt;
    logic                  r_ber_en, w_ber_en_nxt;
    logic [NB_PH_SEL-1:0]  r_phase_sel, w_phase_sel_nxt;
    logic                  r_busy, w_busy_nxt;
    logic                  r_locked, w_locked_nxt;

    logic w_tmr_clear;
    logic w_tmr_run;
    logic w_tmr_expire;
    logic w_samp_reached;
    logic w_rescan_req;

    ber_scan_timer #(
        .NB_TIMER       (NB_TIMER),
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_timer (
        .clk      (clk),
        .i_rst    (i_rst),
        .i_clear  (w_tmr_clear),
        .i_run    (w_tmr_run),
        .o_expire (w_tmr_expire)
    );

    assign w_samp_reached = sat_reached(C_MAX_CNT_W'(i_ber_samp),
                                        C_MAX_CNT_W'(MEAS_SAMPLES), NB_BER_CNT);

`ifdef BER_SCAN_RESCAN_EN
    // Armed from the second LOCKED cycle so the checker restart has landed.
    logic r_lock_armed;

    always_ff @(posedge clk) begin
        if (i_rst) begin
            r_lock_armed <= 1'b0;
        end else begin
            r_lock_armed <= (r_state == ST_LOCKED) && (w_state_nxt == ST_LOCKED);
        end
    end

    assign w_rescan_req = r_lock_armed && (i_rescan_thr != '1)
                        && (i_ber_error > i_rescan_thr);
`else
    assign w_rescan_req = 1'b0;
`endif

    always_comb begin
        w_state_nxt    = r_state;
        w_ph_nxt       = r_ph;
        w_best_ph_nxt  = r_best_ph;
        w_best_err_nxt = r_best_err;
        w_err_nxt      = r_err;
        w_timeout_nxt  = r_timeout;
        w_tmr_clear    = 1'b0;
        w_tmr_run      = 1'b0;

        case (r_state)
            ST_IDLE, ST_LOCKED: begin
                if (i_start || ((r_state == ST_LOCKED) && w_rescan_req)) begin
                    w_state_nxt    = ST_RESTART;
                    w_ph_nxt       = '0;
                    w_best_ph_nxt  = '0;
                    w_best_err_nxt = '1;
                    w_timeout_nxt  = 1'b0;
                end
            end
            ST_RESTART: begin
                w_tmr_clear = 1'b1;
                w_state_nxt = ST_GUARD;
            end
            // Counters still hold pre-restart values here; never sample them.
            ST_GUARD: begin
                w_state_nxt = ST_WAIT;
            end
            ST_WAIT: begin
                w_tmr_run = 1'b1;
                if (w_samp_reached) begin
                    w_err_nxt   = i_ber_error;
                    w_state_nxt = ST_EVAL;
                end else if (w_tmr_expire) begin
                    w_err_nxt     = '1;
                    w_timeout_nxt = 1'b1;
                    w_state_nxt   = ST_EVAL;
                end
            end
            ST_EVAL: begin
                if (r_err < r_best_err) begin
                    w_best_err_nxt = r_err;
                    w_best_ph_nxt  = r_ph;
                end
                if (r_ph == NB_PH_SEL'(N_PHASES - 1)) begin
                    w_state_nxt = ST_FINAL_RST;
                end else begin
                    w_ph_nxt    = r_ph + NB_PH_SEL'(1);
                    w_state_nxt = ST_RESTART;
                end
            end
            ST_FINAL_RST: begin
                w_state_nxt = ST_LOCKED;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase

        // Outputs are registered alongside the state they belong to.
        w_ber_rst_nxt   = (w_state_nxt == ST_RESTART) || (w_state_nxt == ST_FINAL_RST);
        w_ber_en_nxt    = (w_state_nxt != ST_IDLE);
        w_busy_nxt      = (w_state_nxt != ST_IDLE) && (w_state_nxt != ST_LOCKED);
        w_locked_nxt    = (w_state_nxt == ST_LOCKED);
        w_phase_sel_nxt = r_phase_sel;
        if (w_state_nxt == ST_RESTART) begin
            w_phase_sel_nxt = w_ph_nxt;
        end else if (w_state_nxt == ST_FINAL_RST) begin
            w_phase_sel_nxt = w_best_ph_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (i_rst) begin
            r_state     <= ST_IDLE;
            r_ph        <= '0;
            r_best_ph   <= '0;
            r_best_err  <= '1;
            r_err       <= '1;
            r_timeout   <= 1'b0;
            r_ber_rst   <= 1'b0;
            r_ber_en    <= 1'b0;
            r_phase_sel <= '0;
            r_busy      <= 1'b0;
            r_locked    <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_ph        <= w_ph_nxt;
            r_best_ph   <= w_best_ph_nxt;
            r_best_err  <= w_best_err_nxt;
            r_err       <= w_err_nxt;
            r_timeout   <= w_timeout_nxt;
            r_ber_rst   <= w_ber_rst_nxt;
            r_ber_en    <= w_ber_en_nxt;
            r_phase_sel <= w_phase_sel_nxt;
            r_busy      <= w_busy_nxt;
            r_locked    <= w_locked_nxt;
        end
    end

    assign o_ber_rst    = r_ber_rst;
    assign o_ber_en     = r_ber_en;
    assign o_phase_sel  = r_phase_sel;
    assign o_busy       = r_busy;
    assign o_locked     = r_locked;
    assign o_best_phase = r_best_ph;
    assign o_best_err   = r_best_err;
    assign o_timeout    = r_timeout;

endmodule

`default_nettype wire
